cmd_ram_sequencer: RTL

- Sits directly downstream of the PCIe command-send block and consumes its send_control conduit (start_ram_addr, send_cmd).
- On a send_cmd pulse, walks the 64x32 command RAM from start_ram_addr and streams each word out on an Avalon-ST source toward the SFP transmit path.
- Stops on the word carrying the last-flag.
- Reports busy, dropped-request and overrun status back to the control block.

---
 rtl/cmd_seq_pkg.sv | 25 ++
 rtl/cmd_seq_rd_delay.sv | 38 +++
 rtl/cmd_ram_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cmd_seq_pkg.sv
// ============================================================================
// Module   : cmd_seq_pkg
// Brief    : Shared constants and FSM state encoding for the command RAM
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmd_seq_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;
    localparam int LAST_BIT   = DEF_DATA_W - 1;
    localparam int MAX_WORDS  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } seq_state_t;

endpackage : cmd_seq_pkg

`default_nettype wire

// File: rtl/cmd_seq_rd_delay.sv
// ============================================================================
// Module   : cmd_seq_rd_delay
// Brief    : Delays the RAM read strobe by RAM_RD_LAT cycles to mark the cycle
//            on which ram_rdata is valid. Only the strobe is delayed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_seq_rd_delay #(
    parameter int RAM_RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rd,
    output logic o_capture
);

    logic [RAM_RD_LAT-1:0] r_vld;

    generate
        if (RAM_RD_LAT == 1) begin : g_lat_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld <= '0;
                else        r_vld <= i_rd;
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld <= '0;
                else        r_vld <= {r_vld[RAM_RD_LAT-2:0], i_rd};
            end
        end
    endgenerate

    assign o_capture = r_vld[RAM_RD_LAT-1];

endmodule : cmd_seq_rd_delay

`default_nettype wire

// File: rtl/cmd_ram_sequencer.sv
// ============================================================================
// Module   : cmd_ram_sequencer
// Brief    : On send_cmd, walks the command RAM from start_ram_addr and streams
//            each word on an Avalon-ST source until the LAST-flagged word.
//            Define CMD_SEQ_TIMEOUT_EN to add the backpressure watchdog and the
//            timeout_err port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_ram_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int RAM_RD_LAT     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] start_ram_addr,
    input  logic              send_cmd,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    output logic              busy,
    output logic              cmd_dropped,
    output logic              overrun
`ifdef CMD_SEQ_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam logic [ADDR_W-1:0] c_last_cnt = ADDR_W'(MAX_WORDS - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_first;
    logic              r_overrun;
    logic              r_cmd_dropped;
    logic              w_capture;
    logic              w_accept;
    logic              w_eop;
    logic              w_xfer;
    logic              w_abort;

    assign w_accept = send_cmd && (r_state == IDLE);
    assign w_eop    = r_data[DATA_W-1] || (r_word_cnt == c_last_cnt);
    assign w_xfer   = (r_state == SEND) && st_ready;

    cmd_seq_rd_delay #(
        .RAM_RD_LAT (RAM_RD_LAT)
    ) u_rd_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd      (ram_rd),
        .o_capture (w_capture)
    );

`ifdef CMD_SEQ_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_timeout_err;

    // Abort fires on the TIMEOUT_CYCLES-th consecutive stalled SEND cycle.
    assign w_abort = (r_state == SEND) && !st_ready &&
                     (r_to_cnt == c_to_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((r_state == SEND) && !st_ready && !w_abort) r_to_cnt <= r_to_cnt + c_to_w'(1);
            else                                             r_to_cnt <= '0;
            if (w_accept)     r_timeout_err <= 1'b0;
            else if (w_abort) r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_abort          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_rd      = 1'b0;
        st_valid    = 1'b0;
        case (r_state)
            IDLE: if (send_cmd) w_state_nxt = READ;
            READ: begin
                ram_rd      = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: if (w_capture) w_state_nxt = SEND;
            SEND: begin
                st_valid = 1'b1;
                if (w_abort)       w_state_nxt = IDLE;
                else if (st_ready) w_state_nxt = w_eop ? IDLE : READ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_word_cnt    <= '0;
            r_data        <= '0;
            r_first       <= 1'b0;
            r_overrun     <= 1'b0;
            r_cmd_dropped <= 1'b0;
        end else begin
            r_cmd_dropped <= send_cmd && (r_state != IDLE);
            if (w_accept) begin
                r_addr     <= start_ram_addr;
                r_word_cnt <= '0;
                r_overrun  <= 1'b0;
                r_first    <= 1'b1;
            end
            if ((r_state == WAIT) && w_capture) r_data <= ram_rdata;
            if (w_xfer) begin
                // eop without the LAST flag means the word budget ran out
                if (w_eop) begin
                    if (!r_data[DATA_W-1]) r_overrun <= 1'b1;
                end else begin
                    r_addr     <= r_addr + 1'b1;
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_first    <= 1'b0;
                end
            end
        end
    end

    assign ram_addr    = r_addr;
    assign st_data     = r_data;
    assign st_sop      = (r_state == SEND) && r_first;
    assign st_eop      = (r_state == SEND) && w_eop;
    assign busy        = (r_state != IDLE);
    assign cmd_dropped = r_cmd_dropped;
    assign overrun     = r_overrun;

endmodule : cmd_ram_sequencer

`default_nettype wire
